// File: rtl/mod_count_match_fsm.sv
// Serial bit-stream monitor: tracks ones/zeros residues over valid bits and flags
// every accepted bit that lands both residues on zero (Mealy hit, registered hit, saturating count).
module mod_count_match_fsm #(
  parameter int ONES_MOD  = 2,
  parameter int ZEROS_MOD = 2,
  parameter int CNT_W     = 16,
  localparam int OW = (ONES_MOD  > 2) ? $clog2(ONES_MOD)  : 1,
  localparam int ZW = (ZEROS_MOD > 2) ? $clog2(ZEROS_MOD) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             data_in,
  input  logic             clear,
  output logic             hit,
  output logic             hit_q,
  output logic [CNT_W-1:0] hit_count,
  output logic [OW-1:0]    ones_res,
  output logic [ZW-1:0]    zeros_res
);

  localparam logic [OW-1:0] ONES_LAST  = OW'(ONES_MOD - 1);
  localparam logic [ZW-1:0] ZEROS_LAST = ZW'(ZEROS_MOD - 1);

  logic          accept;
  logic [OW-1:0] ones_nxt;
  logic [ZW-1:0] zeros_nxt;
  logic          cnt_sat;

  always_comb begin
    accept    = in_valid & ~clear & ~reset;
    ones_nxt  = ones_res;
    zeros_nxt = zeros_res;
    if (accept) begin
      // Explicit wrap so non-power-of-2 moduli never walk into unused codes.
      if (data_in) ones_nxt  = (ones_res  == ONES_LAST)  ? '0 : ones_res  + 1'b1;
      else         zeros_nxt = (zeros_res == ZEROS_LAST) ? '0 : zeros_res + 1'b1;
    end
    hit     = accept & (ones_nxt == '0) & (zeros_nxt == '0);
    cnt_sat = &hit_count;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ones_res  <= '0;
      zeros_res <= '0;
      hit_q     <= 1'b0;
      hit_count <= '0;
    end else begin
      ones_res  <= ones_nxt;
      zeros_res <= zeros_nxt;
      hit_q     <= hit;
      if (hit && !cnt_sat) hit_count <= hit_count + 1'b1;
    end
  end

endmodule
